multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
//   Parametrised multi-cycle ripple adder, WIDTH bits, processed DIGIT bits per clock, LSB first.
//   Generalises the 1-bit full adder (A, B, Cin -> S, Cout) into a start/done sequential unit.
//   Trades latency for area; feeds ALU/datapath exercises needing N-bit add with carry and overflow.
// PARAMETERS
//   WIDTH  8  operand/result width in bits, >= 1
//   DIGIT  1  bits added per clock; WIDTH % DIGIT == 0 required (elaboration error otherwise)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   A      in   WIDTH  operand A, captured when start accepted
//   B      in   WIDTH  operand B, captured when start accepted
//   Cin    in   1      carry-in, captured when start accepted
//   sub    in   1      subtract select; present only with MULTICYCLE_ADDER_SUB_EN
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse: S/Cout/V valid
//   S      out  WIDTH  sum, held until next completion
//   Cout   out  1      carry out of MSB
//   V      out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   Reset (rst=1 at clock edge): state=IDLE; busy=0, done=0, S=0, Cout=0, V=0; op regs cleared.
//   Reset takes priority over every event, incl. mid-RUN: operation aborted, no done pulse.
//   N = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 at edge k -> capture A, B, Cin into op regs; digit counter=0; -> RUN.
//   RUN: each edge adds the next DIGIT-bit slice of A and B plus the running carry (ripple of DIGIT
//     full adders); sum slice shifted into an internal result register; carry registered.
//     Edge k+N completes the last slice -> DONE; S, Cout, V loaded from internal regs at this edge.
//   DONE: done=1 for exactly one cycle (cycle after edge k+N); next edge -> IDLE, done=0.
//   Latency: done high N cycles after the edge that accepted start; next start is accepted
//     at edge k+N+2 at the earliest (throughput one op per N+2 cycles).
//   start while busy or in DONE: ignored, not queued. A/B/Cin changes after capture have no effect.
//   busy=1 exactly in RUN (N cycles). S/Cout/V change only on entry to DONE or on reset.
//   Width rules: S = (A + B + Cin) mod 2^WIDTH; Cout = bit WIDTH of the full sum.
//   V: internal carry into MSB captured during the final slice; WIDTH=1 -> V = Cin_into_bit0 ^ Cout.
//   Counter width = $clog2(N)+1; wrap not possible (leaves RUN at N-1 slices processed).
// CONFIGURATION
//   MULTICYCLE_ADDER_SUB_EN defined: port sub exists; when sub=1 at start acceptance, B captured as
//     ~B and carry-in forced to 1 (Cin ignored) -> S = A - B; Cout = 1 means no borrow; V = signed
//     subtraction overflow. sub=0 behaves exactly as the add-only build.
//   Not defined: no sub port; add only; identical timing in both builds.
// TESTING
//   WIDTH=1,DIGIT=1: all 8 {Cin,A,B} combos -> S/Cout match full-adder truth table; done 1 cycle after start.
//   WIDTH=8,DIGIT=1: A=0xFF,B=0x01,Cin=0 -> S=0x00,Cout=1,V=0; done exactly 8 cycles after start edge.
//   WIDTH=8,DIGIT=1: A=0x7F,B=0x01,Cin=0 -> S=0x80,Cout=0,V=1; busy high 8 cycles, done 1 cycle.
//   WIDTH=8,DIGIT=4: A=0x5A,B=0x3C,Cin=1 -> S=0x97,Cout=0,V=1; done 2 cycles after start.
//   start pulsed mid-RUN and in DONE -> ignored, single done; rst at RUN cycle 3 -> all outputs 0, no done.
//   SUB_EN, WIDTH=8: A=0x05,B=0x07,sub=1 -> S=0xFE,Cout=0,V=0; A=0x80,B=0x01 -> S=0x7F,Cout=1,V=1.

Source files
------------

// File: rtl/multicycle_adder_if.sv
// multicycle_adder_if
//   Request/result bundle for multicycle_adder.
//   Parameter WIDTH must match the WIDTH of the adder it is connected to.
//   Optional feature macro: MULTICYCLE_ADDER_SUB_EN (adds the sub select).
//   Signals:
//     start  request, sampled by the adder only while idle
//     A, B   operands (WIDTH bits), Cin carry-in; captured when start is accepted
//     sub    subtract select (MULTICYCLE_ADDER_SUB_EN builds only)
//     busy   high while the adder is processing slices
//     done   one-cycle pulse, S/Cout/V valid
//     S      sum (WIDTH bits), Cout carry out of MSB, V signed overflow
//   Modports: master drives requests, slave is the adder.
interface multicycle_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;

    modport master (
        output start, A, B, Cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, S, Cout, V
    );

    modport slave (
        input  start, A, B, Cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, S, Cout, V
    );
endinterface

// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Sequential ripple adder: WIDTH-bit operands, DIGIT bits added per clock, LSB slice first.
//   A start accepted in idle captures the operands; N = WIDTH/DIGIT clocks later done pulses
//   for one cycle with S/Cout/V loaded. Next start can be accepted two clocks after that.
//   Optional feature macro: MULTICYCLE_ADDER_SUB_EN -- when defined, bus.sub=1 at acceptance
//   computes A - B (B inverted, carry-in forced to 1). Timing is identical in both builds.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; aborts any operation without a done pulse
//     bus  multicycle_adder_if slave modport (start/A/B/Cin[/sub] in, busy/done/S/Cout/V out)
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic             clk,
    input logic             rst,
    multicycle_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("multicycle_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {s_idle, s_run, s_done} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_ctop;  // carry into the top bit of the current slice
    logic [WIDTH+DIGIT-1:0] res_shift;

    // Ripple of DIGIT full adders over the low slice of the operand shift registers.
    always_comb begin
        logic c;
        c          = carry_q;
        slice_sum  = '0;
        slice_ctop = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            slice_ctop   = c;
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c;
    end

    // New slice enters at the top; after N slices the LSB slice has reached bit 0.
    assign res_shift = {slice_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        unique case (state_q)
            s_idle: begin
                if (bus.start) begin
                    a_d = bus.A;
`ifdef MULTICYCLE_ADDER_SUB_EN
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub ? 1'b1 : bus.Cin;
`else
                    b_d     = bus.B;
                    carry_d = bus.Cin;
`endif
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = s_run;
                end
            end
            s_run: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Last slice: its top-bit carry-in is the carry into the MSB.
                    s_d     = res_shift[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = slice_cout;
                    v_d     = slice_ctop ^ slice_cout;
                    state_d = s_done;
                end
            end
            s_done:  state_d = s_idle;
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= s_idle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy = (state_q == s_run);
    assign bus.done = (state_q == s_done);
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.V    = v_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder
//   Three adders driven in lockstep from one stimulus stream:
//     u0 WIDTH=1 DIGIT=1, u1 WIDTH=8 DIGIT=1, u2 WIDTH=8 DIGIT=4.
//   A cycle-level model (cycles since acceptance + arithmetic sum/overflow) is checked against
//   every output of every instance on each falling edge; directed vectors add literal checks.
module tb_multicycle_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       cin_in = 1'b0;
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(1)) if0 ();
    multicycle_adder_if #(.WIDTH(8)) if1 ();
    multicycle_adder_if #(.WIDTH(8)) if2 ();

    assign if0.start = start;
    assign if0.A     = a_in[0];
    assign if0.B     = b_in[0];
    assign if0.Cin   = cin_in;
    assign if1.start = start;
    assign if1.A     = a_in;
    assign if1.B     = b_in;
    assign if1.Cin   = cin_in;
    assign if2.start = start;
    assign if2.A     = a_in;
    assign if2.B     = b_in;
    assign if2.Cin   = cin_in;
`ifdef MULTICYCLE_ADDER_SUB_EN
    assign if0.sub = 1'b0;
    assign if1.sub = 1'b0;
    assign if2.sub = 1'b0;
`endif

    multicycle_adder #(.WIDTH(1), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    multicycle_adder #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    multicycle_adder #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic       busy_v [3];
    logic       done_v [3];
    logic       cout_v [3];
    logic       v_v    [3];
    logic [7:0] s_v    [3];

    assign busy_v[0] = if0.busy;
    assign busy_v[1] = if1.busy;
    assign busy_v[2] = if2.busy;
    assign done_v[0] = if0.done;
    assign done_v[1] = if1.done;
    assign done_v[2] = if2.done;
    assign cout_v[0] = if0.Cout;
    assign cout_v[1] = if1.Cout;
    assign cout_v[2] = if2.Cout;
    assign v_v[0]    = if0.V;
    assign v_v[1]    = if1.V;
    assign v_v[2]    = if2.V;
    assign s_v[0]    = {7'b0, if0.S};
    assign s_v[1]    = if1.S;
    assign s_v[2]    = if2.S;

    function automatic int wid(input int i);
        return (i == 0) ? 1 : 8;
    endfunction

    function automatic int nslc(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 8 : 2);
    endfunction

    // Returns {V, Cout, S[7:0]} for a w-bit add, from plain integer arithmetic.
    function automatic logic [9:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
        int mask, ua, ub, full, sa, sb, tot;
        logic cy, ov;
        mask = (1 << w) - 1;
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        full = ua + ub + int'(c);
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        tot  = sa + sb + int'(c);
        cy   = ((full >> w) & 1) != 0;
        ov   = (tot > (1 << (w - 1)) - 1) || (tot < -(1 << (w - 1)));
        return {ov, cy, 8'(full & mask)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..n busy, n+1 done pulse.
    int         phase [3];
    logic [7:0] m_s [3];
    logic       m_c [3];
    logic       m_v [3];
    logic [7:0] p_s [3];
    logic       p_c [3];
    logic       p_v [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                phase[i] <= 0;
                m_s[i]   <= 8'h00;
                m_c[i]   <= 1'b0;
                m_v[i]   <= 1'b0;
            end else if (phase[i] == 0) begin
                if (start) begin
                    phase[i] <= 1;
                    {p_v[i], p_c[i], p_s[i]} <= ref_add(wid(i), a_in, b_in, cin_in);
                end
            end else if (phase[i] < nslc(i)) begin
                phase[i] <= phase[i] + 1;
            end else if (phase[i] == nslc(i)) begin
                phase[i] <= nslc(i) + 1;
                m_s[i]   <= p_s[i];
                m_c[i]   <= p_c[i];
                m_v[i]   <= p_v[i];
            end else begin
                phase[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.busy", i), 32'(busy_v[i]),
                    32'(phase[i] >= 1 && phase[i] <= nslc(i)));
                chk($sformatf("u%0d.done", i), 32'(done_v[i]), 32'(phase[i] == nslc(i) + 1));
                chk($sformatf("u%0d.S", i), 32'(s_v[i]), 32'(m_s[i]));
                chk($sformatf("u%0d.Cout", i), 32'(cout_v[i]), 32'(m_c[i]));
                chk($sformatf("u%0d.V", i), 32'(v_v[i]), 32'(m_v[i]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic c, input int tgt,
                           input int lat, input logic [7:0] es, input logic ec, input logic ev);
        int cyc;
        int nbusy;
        bit seen;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && cyc < 20) begin
            if (busy_v[tgt]) nbusy++;
            if (done_v[tgt]) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        chk($sformatf("lat u%0d %h+%h+%0d", tgt, a, b, c), 32'(cyc), 32'(lat));
        chk($sformatf("busycnt u%0d", tgt), 32'(nbusy), 32'(lat));
        chk($sformatf("litS u%0d %h+%h+%0d", tgt, a, b, c), 32'(s_v[tgt]), 32'(es));
        chk($sformatf("litCout u%0d", tgt), 32'(cout_v[tgt]), 32'(ec));
        chk($sformatf("litV u%0d", tgt), 32'(v_v[tgt]), 32'(ev));
        repeat (10) tick();
    endtask

    initial begin
        int ndone;
        // Nonzero inputs with start low during reset must not be captured.
        a_in   = 8'hA5;
        b_in   = 8'h3C;
        cin_in = 1'b1;
        rst    = 1'b1;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst u%0d.S", i), 32'(s_v[i]), 32'h0);
            chk($sformatf("rst u%0d.busy", i), 32'(busy_v[i]), 32'h0);
            chk($sformatf("rst u%0d.done", i), 32'(done_v[i]), 32'h0);
        end
        rst = 1'b0;
        tick();

        // Full-adder truth table on the 1-bit instance.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 2; ai++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    logic fs, fc;
                    fs = 1'(ai ^ bi ^ ci);
                    fc = 1'((ai & bi) | (ai & ci) | (bi & ci));
                    run_vec(8'(ai), 8'(bi), 1'(ci), 0, 1, {7'b0, fs}, fc, 1'(ci) ^ fc);
                end
            end
        end

        run_vec(8'hFF, 8'h01, 1'b0, 1, 8, 8'h00, 1'b1, 1'b0);
        run_vec(8'h7F, 8'h01, 1'b0, 1, 8, 8'h80, 1'b0, 1'b1);
        run_vec(8'h5A, 8'h3C, 1'b1, 2, 2, 8'h97, 1'b0, 1'b1);
        run_vec(8'h5A, 8'h3C, 1'b1, 1, 8, 8'h97, 1'b0, 1'b1);
        run_vec(8'hFF, 8'hFF, 1'b1, 2, 2, 8'hFF, 1'b1, 1'b0);
        run_vec(8'h80, 8'h80, 1'b0, 1, 8, 8'h00, 1'b1, 1'b1);

        // start pulsed mid-RUN (edge k+3) and in DONE (edge k+9) on u1: ignored there.
        a_in   = 8'h12;
        b_in   = 8'h34;
        cin_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (done_v[1]) ndone++;
            if (cyc == 2) begin
                a_in = 8'h01;
                b_in = 8'h01;
            end
            start = (cyc == 2 || cyc == 8);
            tick();
        end
        start = 1'b0;
        chk("ignore u1 done count", 32'(ndone), 32'd1);
        chk("ignore u1 S", 32'(s_v[1]), 32'h46);
        repeat (10) tick();

        // Reset at RUN cycle 3 aborts without a done pulse.
        a_in   = 8'h77;
        b_in   = 8'h11;
        cin_in = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort u%0d.S", i), 32'(s_v[i]), 32'h0);
            chk($sformatf("abort u%0d.Cout", i), 32'(cout_v[i]), 32'h0);
            chk($sformatf("abort u%0d.V", i), 32'(v_v[i]), 32'h0);
            chk($sformatf("abort u%0d.busy", i), 32'(busy_v[i]), 32'h0);
        end
        rst   = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done_v[1]) ndone++;
            tick();
        end
        chk("abort u1 no done", 32'(ndone), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
